// File: rtl/video_timing_gen.sv
// Raster timing generator for the DVI output path.
// Issues pixel-fetch coordinates, then delays sync/blank by the pixel source's
// fixed latency so they line up with the RGB data it returns.
module video_timing_gen #(
  parameter int   p_h_active      = 640,
  parameter int   p_h_front       = 16,
  parameter int   p_h_sync        = 96,
  parameter int   p_h_back        = 48,
  parameter int   p_v_active      = 480,
  parameter int   p_v_front       = 10,
  parameter int   p_v_sync        = 2,
  parameter int   p_v_back        = 33,
  parameter logic p_hsync_pol     = 1'b0,
  parameter logic p_vsync_pol     = 1'b0,
  parameter int   p_fetch_latency = 2,
  localparam int  h_total         = p_h_active + p_h_front + p_h_sync + p_h_back,
  localparam int  v_total         = p_v_active + p_v_front + p_v_sync + p_v_back,
  localparam int  h_w             = $clog2(h_total),
  localparam int  v_w             = $clog2(v_total)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic [h_w-1:0]       o_fetch_x,
  output logic [v_w-1:0]       o_fetch_y,
  output logic                 o_fetch_en,
  output logic                 o_frame_start,
  output logic                 o_line_start,
  input  logic [2:0][7:0]      i_data,
  output logic                 o_hsync,
  output logic                 o_vsync,
  output logic                 o_blank,
  output logic [2:0][7:0]      o_data
);

  // Reject configurations that would produce a degenerate raster or an
  // alignment pipeline deeper than the pixel sources we support.
  if (p_h_active <= 0 || p_h_front <= 0 || p_h_sync <= 0 || p_h_back <= 0 ||
      p_v_active <= 0 || p_v_front <= 0 || p_v_sync <= 0 || p_v_back <= 0 ||
      p_fetch_latency < 0 || p_fetch_latency > 8) begin : g_bad_cfg
    $error("video_timing_gen: illegal timing configuration");
  end

  // Counter boundaries, pre-sized to the counter widths.
  localparam logic [h_w-1:0] h_last_c       = h_w'(h_total - 1);
  localparam logic [h_w-1:0] h_active_c     = h_w'(p_h_active);
  localparam logic [h_w-1:0] h_sync_start_c = h_w'(p_h_active + p_h_front);
  localparam logic [h_w-1:0] h_sync_end_c   = h_w'(p_h_active + p_h_front + p_h_sync);
  localparam logic [v_w-1:0] v_last_c       = v_w'(v_total - 1);
  localparam logic [v_w-1:0] v_active_c     = v_w'(p_v_active);
  localparam logic [v_w-1:0] v_sync_start_c = v_w'(p_v_active + p_v_front);
  localparam logic [v_w-1:0] v_sync_end_c   = v_w'(p_v_active + p_v_front + p_v_sync);

  logic [h_w-1:0] h_cnt_reg, h_cnt_next;
  logic [v_w-1:0] v_cnt_reg, v_cnt_next;
  logic           h_wrap, v_wrap;
  logic           fetch_en;
  logic           hs_raw, vs_raw, blank_raw;
  logic           hs_dly, vs_dly, blank_dly;

  // Next raster position: x wraps every line, y advances only on an x wrap.
  always_comb begin
    h_wrap     = (h_cnt_reg == h_last_c);
    v_wrap     = (v_cnt_reg == v_last_c);
    h_cnt_next = h_wrap ? '0 : h_cnt_reg + h_w'(1);
    v_cnt_next = v_cnt_reg;
    if (h_wrap) begin
      v_cnt_next = v_wrap ? '0 : v_cnt_reg + v_w'(1);
    end
  end

  // Raster position registers; reset parks the raster at (0, 0).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // Fetch-stage outputs come straight off the counters, with no added delay.
  assign o_fetch_x     = h_cnt_reg;
  assign o_fetch_y     = v_cnt_reg;
  assign fetch_en      = (h_cnt_reg < h_active_c) && (v_cnt_reg < v_active_c);
  assign o_fetch_en    = fetch_en;
  assign o_frame_start = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign o_line_start  = (h_cnt_reg == '0);

  // Raw timing flags are kept as "asserted" booleans; polarity is applied only
  // at the output register. vsync covers whole lines, blanking pixels included.
  assign hs_raw    = (h_cnt_reg >= h_sync_start_c) && (h_cnt_reg < h_sync_end_c);
  assign vs_raw    = (v_cnt_reg >= v_sync_start_c) && (v_cnt_reg < v_sync_end_c);
  assign blank_raw = ~fetch_en;

  // Delay the raw flags by the fetch latency so they meet the returned pixel.
  if (p_fetch_latency == 0) begin : g_no_delay
    assign hs_dly    = hs_raw;
    assign vs_dly    = vs_raw;
    assign blank_dly = blank_raw;
  end else begin : g_delay
    logic [p_fetch_latency-1:0] hs_pipe_reg, vs_pipe_reg, blank_pipe_reg;
    logic [p_fetch_latency-1:0] hs_pipe_next, vs_pipe_next, blank_pipe_next;

    for (genvar gi = 0; gi < p_fetch_latency; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign hs_pipe_next[gi]    = hs_raw;
        assign vs_pipe_next[gi]    = vs_raw;
        assign blank_pipe_next[gi] = blank_raw;
      end else begin : g_tail
        assign hs_pipe_next[gi]    = hs_pipe_reg[gi-1];
        assign vs_pipe_next[gi]    = vs_pipe_reg[gi-1];
        assign blank_pipe_next[gi] = blank_pipe_reg[gi-1];
      end
    end

    // Shift the flags one stage per pixel; reset fills the pipe with idle
    // (sync deasserted, blanked) so no stale pulse escapes after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        hs_pipe_reg    <= '0;
        vs_pipe_reg    <= '0;
        blank_pipe_reg <= '1;
      end else begin
        hs_pipe_reg    <= hs_pipe_next;
        vs_pipe_reg    <= vs_pipe_next;
        blank_pipe_reg <= blank_pipe_next;
      end
    end

    assign hs_dly    = hs_pipe_reg[p_fetch_latency-1];
    assign vs_dly    = vs_pipe_reg[p_fetch_latency-1];
    assign blank_dly = blank_pipe_reg[p_fetch_latency-1];
  end

  // Output register: apply sync polarity and force black while blanked.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hsync <= ~p_hsync_pol;
      o_vsync <= ~p_vsync_pol;
      o_blank <= 1'b1;
      o_data  <= '0;
    end else begin
      o_hsync <= hs_dly ? p_hsync_pol : ~p_hsync_pol;
      o_vsync <= vs_dly ? p_vsync_pol : ~p_vsync_pol;
      o_blank <= blank_dly;
      o_data  <= blank_dly ? '0 : i_data;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three small-raster instances (latency 2, 0, 8)
// and one default 640x480 instance share a clock and reset. A pixel source
// returns salted {x, y, x^y} after each instance's latency; a raster model
// computed from the frame timing rules supplies every expected value.
module tb_video_timing_gen;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb, lat;
  } cfg_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] salt    = '0;
  cfg_t        cfg [4];
  int          k_model = 0;
  int          wp      = 0;
  logic [23:0] hist [4][16];
  logic [23:0] src_data [4];

  logic [3:0]  fx0, fx1, fx2;
  logic [2:0]  fy0, fy1, fy2;
  logic [9:0]  fx3, fy3;
  wire  [15:0] fx_w [4];
  wire  [15:0] fy_w [4];
  wire  [3:0]  en_w, fs_w, ls_w, hs_w, vs_w, bl_w;
  wire  [23:0] od_w [4];

  assign fx_w[0] = 16'(fx0);
  assign fx_w[1] = 16'(fx1);
  assign fx_w[2] = 16'(fx2);
  assign fx_w[3] = 16'(fx3);
  assign fy_w[0] = 16'(fy0);
  assign fy_w[1] = 16'(fy1);
  assign fy_w[2] = 16'(fy2);
  assign fy_w[3] = 16'(fy3);

  video_timing_gen #(.p_h_active(8), .p_h_front(2), .p_h_sync(2), .p_h_back(2),
    .p_v_active(4), .p_v_front(1), .p_v_sync(1), .p_v_back(1),
    .p_hsync_pol(1'b0), .p_vsync_pol(1'b0), .p_fetch_latency(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .o_fetch_x(fx0), .o_fetch_y(fy0),
    .o_fetch_en(en_w[0]), .o_frame_start(fs_w[0]), .o_line_start(ls_w[0]),
    .i_data(src_data[0]), .o_hsync(hs_w[0]), .o_vsync(vs_w[0]),
    .o_blank(bl_w[0]), .o_data(od_w[0]));

  video_timing_gen #(.p_h_active(8), .p_h_front(2), .p_h_sync(2), .p_h_back(2),
    .p_v_active(4), .p_v_front(1), .p_v_sync(1), .p_v_back(1),
    .p_hsync_pol(1'b0), .p_vsync_pol(1'b0), .p_fetch_latency(0)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .o_fetch_x(fx1), .o_fetch_y(fy1),
    .o_fetch_en(en_w[1]), .o_frame_start(fs_w[1]), .o_line_start(ls_w[1]),
    .i_data(src_data[1]), .o_hsync(hs_w[1]), .o_vsync(vs_w[1]),
    .o_blank(bl_w[1]), .o_data(od_w[1]));

  video_timing_gen #(.p_h_active(8), .p_h_front(2), .p_h_sync(2), .p_h_back(2),
    .p_v_active(4), .p_v_front(1), .p_v_sync(1), .p_v_back(1),
    .p_hsync_pol(1'b0), .p_vsync_pol(1'b0), .p_fetch_latency(8)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .o_fetch_x(fx2), .o_fetch_y(fy2),
    .o_fetch_en(en_w[2]), .o_frame_start(fs_w[2]), .o_line_start(ls_w[2]),
    .i_data(src_data[2]), .o_hsync(hs_w[2]), .o_vsync(vs_w[2]),
    .o_blank(bl_w[2]), .o_data(od_w[2]));

  video_timing_gen u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .o_fetch_x(fx3), .o_fetch_y(fy3),
    .o_fetch_en(en_w[3]), .o_frame_start(fs_w[3]), .o_line_start(ls_w[3]),
    .i_data(src_data[3]), .o_hsync(hs_w[3]), .o_vsync(vs_w[3]),
    .o_blank(bl_w[3]), .o_data(od_w[3]));

  // Raster model: cycles since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k_model <= 0;
    else        k_model <= k_model + 1;
  end

  function automatic int htot(cfg_t c);
    return c.ha + c.hf + c.hs + c.hb;
  endfunction

  function automatic int vtot(cfg_t c);
    return c.va + c.vf + c.vs + c.vb;
  endfunction

  function automatic logic [23:0] pix(int x, int y);
    logic [7:0] xb, yb;
    xb = x[7:0];
    yb = y[7:0];
    return {xb ^ salt[23:16], yb ^ salt[15:8], (xb ^ yb) ^ salt[7:0]};
  endfunction

  // {x, y, fetch_en, frame_start, line_start} expected k cycles after release.
  function automatic logic [34:0] exp_fetch(cfg_t c, int k);
    int x, y;
    x = k % htot(c);
    y = (k / htot(c)) % vtot(c);
    return {16'(x), 16'(y), (x < c.ha) && (y < c.va), (x == 0) && (y == 0), x == 0};
  endfunction

  // {hsync, vsync, blank, rgb} expected k cycles after release (active-low syncs).
  function automatic logic [26:0] exp_out(cfg_t c, int k);
    int p, x, y;
    logic act, hs_on, vs_on;
    if (k < c.lat + 1) return {3'b111, 24'd0};
    p     = k - c.lat - 1;
    x     = p % htot(c);
    y     = (p / htot(c)) % vtot(c);
    act   = (x < c.ha) && (y < c.va);
    hs_on = (x >= c.ha + c.hf) && (x < c.ha + c.hf + c.hs);
    vs_on = (y >= c.va + c.vf) && (y < c.va + c.vf + c.vs);
    return {~hs_on, ~vs_on, ~act, act ? pix(x, y) : 24'd0};
  endfunction

  // Pixel source: answers each instance's fetch after that instance's latency.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (cfg[i].lat == 0) src_data[i] <= pix(int'(fx_w[i]), int'(fy_w[i]));
      else                 src_data[i] <= hist[i][4'(wp - cfg[i].lat)];
      hist[i][4'(wp)] <= pix(int'(fx_w[i]), int'(fy_w[i]));
    end
    wp <= wp + 1;
  end

  task automatic release_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({fx_w[i], fy_w[i], en_w[i], fs_w[i], ls_w[i]} !== {32'd0, 3'b111}) begin
        n_fail++;
        $display("FAIL reset_fetch[%0d] got=%h exp=%h", i,
                 {fx_w[i], fy_w[i], en_w[i], fs_w[i], ls_w[i]}, {32'd0, 3'b111});
      end
      n_tests++;
      if ({hs_w[i], vs_w[i], bl_w[i], od_w[i]} !== {3'b111, 24'd0}) begin
        n_fail++;
        $display("FAIL reset_out[%0d] got=%h exp=%h", i,
                 {hs_w[i], vs_w[i], bl_w[i], od_w[i]}, {3'b111, 24'd0});
      end
    end
    $display("[TB] test_reset: idle state checked on 4 instances");
  endtask

  task automatic test_fetch_counters(int ncyc);
    int last_fs = -1;
    int last_ls = -1;
    logic [34:0] exp;
    repeat (ncyc) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        exp = exp_fetch(cfg[i], k_model);
        n_tests++;
        if ({fx_w[i], fy_w[i], en_w[i], fs_w[i], ls_w[i]} !== exp) begin
          n_fail++;
          $display("FAIL fetch[%0d] k=%0d got=%h exp=%h", i, k_model,
                   {fx_w[i], fy_w[i], en_w[i], fs_w[i], ls_w[i]}, exp);
        end
      end
      if (fs_w[0]) begin
        if (last_fs >= 0) begin
          n_tests++;
          if (k_model - last_fs !== 98) begin
            n_fail++;
            $display("FAIL frame_period got=%0d exp=98", k_model - last_fs);
          end
        end
        last_fs = k_model;
      end
      if (ls_w[3]) begin
        if (last_ls >= 0) begin
          n_tests++;
          if (k_model - last_ls !== 800) begin
            n_fail++;
            $display("FAIL line_period_default got=%0d exp=800", k_model - last_ls);
          end
        end
        last_ls = k_model;
      end
    end
    $display("[TB] test_fetch_counters: %0d cycles", ncyc);
  endtask

  task automatic test_alignment(int ncyc);
    logic [26:0] exp;
    repeat (ncyc) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        exp = exp_out(cfg[i], k_model);
        n_tests++;
        if ({hs_w[i], vs_w[i], bl_w[i], od_w[i]} !== exp) begin
          n_fail++;
          $display("FAIL align[%0d] k=%0d got=%h exp=%h", i, k_model,
                   {hs_w[i], vs_w[i], bl_w[i], od_w[i]}, exp);
        end
      end
    end
    $display("[TB] test_alignment: %0d cycles", ncyc);
  endtask

  // Any whole frame of the small raster has 14 hsync-low, 14 vsync-low and
  // 32 visible cycles; any 800 cycles early in a 640x480 frame have 96 and 640.
  task automatic test_sync_counts();
    int hs_lo [4];
    int vs_lo [4];
    int act   [4];
    for (int i = 0; i < 4; i++) begin
      hs_lo[i] = 0; vs_lo[i] = 0; act[i] = 0;
    end
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (i == 3 || c < 98) begin
          if (!hs_w[i]) hs_lo[i]++;
          if (!vs_w[i]) vs_lo[i]++;
          if (!bl_w[i]) act[i]++;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({hs_lo[i], vs_lo[i], act[i]} !== ((i == 3) ? {32'd96, 32'd0, 32'd640}
                                                   : {32'd14, 32'd14, 32'd32})) begin
        n_fail++;
        $display("FAIL sync_counts[%0d] hs_lo=%0d vs_lo=%0d visible=%0d", i,
                 hs_lo[i], vs_lo[i], act[i]);
      end
    end
    $display("[TB] test_sync_counts: per-frame sync/visible totals checked");
  endtask

  task automatic test_mid_reset();
    int bound = 0;
    int hold;
    while (!(fx_w[0] == 16'd5 && fy_w[0] == 16'd2) && bound < 400) begin
      @(negedge clk);
      bound++;
    end
    n_tests++;
    if (bound >= 400) begin
      n_fail++;
      $display("FAIL mid_reset_wait got=timeout exp=fetch(5,2)");
    end
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({fx_w[i], fy_w[i], en_w[i], fs_w[i], ls_w[i], hs_w[i], vs_w[i], bl_w[i], od_w[i]}
          !== {32'd0, 6'b111111, 24'd0}) begin
        n_fail++;
        $display("FAIL mid_reset_state[%0d] got=%h exp=%h", i,
                 {fx_w[i], fy_w[i], en_w[i], fs_w[i], ls_w[i], hs_w[i], vs_w[i], bl_w[i], od_w[i]},
                 {32'd0, 6'b111111, 24'd0});
      end
    end
    hold = int'($urandom_range(1, 3));
    repeat (hold) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({fx_w[i], fy_w[i]} !== {16'd1, 16'd0}) begin
        n_fail++;
        $display("FAIL restart_pos[%0d] got=(%0d,%0d) exp=(1,0)", i, fx_w[i], fy_w[i]);
      end
      n_tests++;
      if ({hs_w[i], vs_w[i], bl_w[i], od_w[i]} !== exp_out(cfg[i], k_model)) begin
        n_fail++;
        $display("FAIL restart_out[%0d] got=%h exp=%h", i,
                 {hs_w[i], vs_w[i], bl_w[i], od_w[i]}, exp_out(cfg[i], k_model));
      end
    end
    $display("[TB] test_mid_reset: reset at (5,2), held %0d cycles", hold);
  endtask

  task automatic test_random_reset();
    int wait_cyc;
    wait_cyc = int'($urandom_range(5, 300));
    repeat (wait_cyc) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({fx_w[i], fy_w[i], hs_w[i], vs_w[i], bl_w[i], od_w[i]} !== {32'd0, 3'b111, 24'd0}) begin
        n_fail++;
        $display("FAIL random_reset_state[%0d] got=%h exp=%h", i,
                 {fx_w[i], fy_w[i], hs_w[i], vs_w[i], bl_w[i], od_w[i]}, {32'd0, 3'b111, 24'd0});
      end
    end
    release_reset();
    $display("[TB] test_random_reset: reset after %0d cycles", wait_cyc);
  endtask

  initial begin
    salt   = 24'($urandom);
    cfg[0] = '{8, 2, 2, 2, 4, 1, 1, 1, 2};
    cfg[1] = '{8, 2, 2, 2, 4, 1, 1, 1, 0};
    cfg[2] = '{8, 2, 2, 2, 4, 1, 1, 1, 8};
    cfg[3] = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    rst_n  = 1'b0;
    test_reset();
    release_reset();
    test_fetch_counters(300);
    test_alignment(300);
    test_sync_counts();
    test_mid_reset();
    test_alignment(150);
    test_random_reset();
    test_fetch_counters(1700);
    test_alignment(400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator sitting directly upstream of the TMDS/DVI output stage, in the pixel clock domain.
- Counts pixels and lines and issues a pixel-fetch address (x, y, enable) to the frame-buffer/pixel source.
- Delays hsync/vsync/blank so they stay aligned with pixel data returned after a fixed fetch latency.
- Produces the hsync, vsync, blank and 3x8-bit RGB bundle that the DVI encoder consumes.

Parameters:
- p_h_active, 640, visible pixels per line
- p_h_front, 16, horizontal front porch (pixels)
- p_h_sync, 96, horizontal sync width (pixels)
- p_h_back, 48, horizontal back porch (pixels)
- p_v_active, 480, visible lines per frame
- p_v_front, 10, vertical front porch (lines)
- p_v_sync, 2, vertical sync width (lines)
- p_v_back, 33, vertical back porch (lines)
- p_hsync_pol, 1'b0, asserted level of o_hsync
- p_vsync_pol, 1'b0, asserted level of o_vsync
- p_fetch_latency, 2, cycles from fetch request to valid i_data (legal range 0..8)

Ports:
- i_clk, in, 1, pixel clock
- i_rst_n, in, 1, asynchronous active-low reset
- o_fetch_x, out, $clog2(H_TOTAL), horizontal counter value for the current fetch cycle
- o_fetch_y, out, $clog2(V_TOTAL), vertical counter value for the current fetch cycle
- o_fetch_en, out, 1, current (x, y) lies inside the active area
- o_frame_start, out, 1, one-cycle pulse when fetch counter is (0, 0)
- o_line_start, out, 1, one-cycle pulse when fetch x == 0 (every line)
- i_data, in, 8 x [3], RGB from the pixel source, valid p_fetch_latency cycles after its request
- o_hsync, out, 1, aligned horizontal sync
- o_vsync, out, 1, aligned vertical sync
- o_blank, out, 1, aligned blanking: 1 outside the active area
- o_data, out, 8 x [3], aligned RGB; forced to 0 while blanked

Behaviour:
- Totals: H_TOTAL = sum of the four horizontal parameters (800); V_TOTAL = sum of the four vertical parameters (525).
- Counters:
  - h_cnt and v_cnt are registers; o_fetch_x = h_cnt and o_fetch_y = v_cnt directly, with no extra delay.
  - h_cnt increments every cycle and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - When both wrap together, the next cycle is (0, 0).
- o_fetch_en = (h_cnt < p_h_active) && (v_cnt < p_v_active); combinational from the counter registers.
- o_frame_start = (h_cnt == 0 && v_cnt == 0); o_line_start = (h_cnt == 0).
- Raw sync (fetch stage):
  - hs_raw asserted for h in [p_h_active + p_h_front, p_h_active + p_h_front + p_h_sync).
  - vs_raw asserted for v in [p_v_active + p_v_front, p_v_active + p_v_front + p_v_sync), for the entire line including blanking pixels.
  - blank_raw = !o_fetch_en.
- Alignment pipeline:
  - hs_raw, vs_raw and blank_raw pass through a shift register of depth p_fetch_latency; p_fetch_latency = 0 means a wire.
  - They then pass through one output register.
  - o_data is registered from i_data in that same output register: o_data <= blank_delayed ? 0 : i_data.
  - Total latency from a fetch cycle to the matching o_* outputs is p_fetch_latency + 1 cycles.
  - Sync outputs drive p_*sync_pol when asserted and the inverse otherwise.
- Reset (asynchronous assert, synchronous deassert handled by the system reset synchroniser):
  - h_cnt = 0, v_cnt = 0.
  - All pipeline stages hold the deasserted sync level and blank = 1.
  - o_hsync = ~p_hsync_pol, o_vsync = ~p_vsync_pol, o_blank = 1, o_data = 0.
  - Fetch outputs reflect (0, 0): o_fetch_en = 1, o_frame_start = 1, o_line_start = 1.
  - The first non-reset clock edge advances to (1, 0).
- Reset mid-frame: everything returns immediately to the reset state above; no partial line is completed.
- No stall or backpressure; the pixel source must honour the fixed latency. i_data is ignored while the delayed blank is 1.
- Illegal configuration: any timing parameter equal to 0, or p_fetch_latency > 8, is a compile-time error (elaboration assertion).

Test Plan:
- Small timing (h 8/2/2/2 -> H_TOTAL 14; v 4/1/1/1 -> V_TOTAL 7), latency 2, sync polarity 0, reset released:
  - o_fetch_x counts 0..13 and wraps.
  - o_fetch_y increments on each x wrap; (13, 6) -> (0, 0) in one cycle.
  - o_frame_start pulses every 98 cycles.
- Same configuration, source returns {x, y, x^y} after 2 cycles:
  - o_data equals the fetched pixel exactly 3 cycles after its request.
  - o_blank is 0 for x < 8 and y < 4.
  - o_data = 0 whenever o_blank = 1.
- Sync placement:
  - o_hsync is low for fetch x = 10..11, observed 3 cycles later, on every line.
  - o_vsync is low for all 14 pixels of fetch line y = 5.
- Latency 0:
  - Outputs lag fetch by exactly 1 cycle.
  - Latency 8: lag is exactly 9 cycles and sync/blank/data stay mutually aligned.
- Assert i_rst_n low at fetch (5, 2):
  - Immediately o_hsync = 1, o_vsync = 1, o_blank = 1, o_data = 0, and fetch outputs show (0, 0).
  - After release, the sequence restarts at (1, 0) with no glitch pulses.
- Default 640x480 configuration:
  - 800 x 525 = 420000 cycles between o_frame_start pulses.
  - Exactly 307200 cycles per frame with o_blank = 0.
